// File: rtl/clock_sched_pkg.sv
// Shared constants and types for the clock-enable scheduler: divisor defaults,
// divisor encodings and the configuration FSM state type.
package clock_sched_pkg;

   localparam int unsigned DIV_W       = 8;
   localparam int unsigned DEFAULT_DIV = 4;

   // Divisor encodings with special meaning
   localparam int unsigned DIV_PARK  = 0;
   localparam int unsigned DIV_EVERY = 1;

   typedef enum logic {
      StIdle,
      StPending
   } cfg_state_e;

   // Channel-index width, kept at least one bit for single-channel builds
   function automatic int unsigned ch_width(input int unsigned num_ch);
      return (num_ch > 1) ? $clog2(num_ch) : 1;
   endfunction

endpackage

// File: rtl/clock_enable_scheduler_if.sv
// Valid/ready configuration port of the clock-enable scheduler.
interface clock_enable_scheduler_if #(
   parameter int unsigned NUM_CH = 3,
   parameter int unsigned DIV_W  = 8
);
   import clock_sched_pkg::*;

   localparam int unsigned CH_W = ch_width(NUM_CH);

   logic             Cfg_Valid;
   logic             Cfg_Ready;
   logic [CH_W-1:0]  Cfg_Channel;
   logic [DIV_W-1:0] Cfg_Divisor;
   logic             Cfg_Error;

   modport master (
      output Cfg_Valid,
      output Cfg_Channel,
      output Cfg_Divisor,
      input  Cfg_Ready,
      input  Cfg_Error
   );

   modport slave (
      input  Cfg_Valid,
      input  Cfg_Channel,
      input  Cfg_Divisor,
      output Cfg_Ready,
      output Cfg_Error
   );

endinterface

// File: rtl/clock_enable_channel.sv
// One tick channel: period counter, divisor register, terminal-count detect and
// registered tick. A load strobe replaces the divisor; at_boundary_o says a load is safe now.
module clock_enable_channel #(
   parameter int unsigned DIV_W       = 8,
   parameter int unsigned DEFAULT_DIV = 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             en_i,
   input  logic             load_i,
   input  logic [DIV_W-1:0] load_div_i,
   output logic             tick_o,
   output logic             at_boundary_o
);
   import clock_sched_pkg::*;

   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W-1:0] div_q, div_d;
   logic             tick_q, tick_d;
   logic             parked;
   logic             term_cnt;

   assign parked   = (div_q == DIV_W'(DIV_PARK));
   assign term_cnt = en_i && !parked && (cnt_q == div_q - 1'b1);

   // Disabled or parked channels have no period in flight, so a load is always safe
   assign at_boundary_o = term_cnt || !en_i || parked;
   assign tick_o        = tick_q;

   always_comb begin
      cnt_d  = cnt_q;
      div_d  = div_q;
      tick_d = 1'b0;
      if (!en_i || parked) begin
         cnt_d = '0;
      end else if (term_cnt) begin
         cnt_d  = '0;
         tick_d = 1'b1;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
      if (load_i) begin
         div_d = load_div_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q  <= '0;
         div_q  <= DIV_W'(DEFAULT_DIV);
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         div_q  <= div_d;
         tick_q <= tick_d;
      end
   end

endmodule

// File: rtl/clock_enable_scheduler.sv
// Per-consumer clock-enable tick generator on the single master clock, with a
// valid/ready port that retimes divisor changes onto each channel's period boundary.
module clock_enable_scheduler #(
   parameter int unsigned NUM_CH      = 3,
   parameter int unsigned DIV_W       = clock_sched_pkg::DIV_W,
   parameter int unsigned DEFAULT_DIV = clock_sched_pkg::DEFAULT_DIV
) (
   input  logic                    Master_Clock_In,
   input  logic                    Reset_N,
   input  logic [NUM_CH-1:0]       Channel_Enable,
   clock_enable_scheduler_if.slave cfg,
   output logic [NUM_CH-1:0]       Tick_Out
);
   import clock_sched_pkg::*;

   localparam int unsigned CH_W = ch_width(NUM_CH);

   cfg_state_e       state_q, state_d;
   logic [CH_W-1:0]  pend_ch_q, pend_ch_d;
   logic [DIV_W-1:0] pend_div_q, pend_div_d;
   logic             err_q, err_d;
   logic [NUM_CH-1:0] load;
   logic [NUM_CH-1:0] at_boundary;

   assign cfg.Cfg_Ready = (state_q == StIdle);
   assign cfg.Cfg_Error = err_q;

   always_comb begin
      state_d    = state_q;
      pend_ch_d  = pend_ch_q;
      pend_div_d = pend_div_q;
      err_d      = 1'b0;
      load       = '0;
      unique case (state_q)
         StIdle: begin
            if (cfg.Cfg_Valid) begin
               if (32'(cfg.Cfg_Channel) >= NUM_CH) begin
                  err_d = 1'b1;
               end else begin
                  pend_ch_d  = cfg.Cfg_Channel;
                  pend_div_d = cfg.Cfg_Divisor;
                  state_d    = StPending;
               end
            end
         end
         StPending: begin
            for (int i = 0; i < NUM_CH; i++) begin
               if ((pend_ch_q == CH_W'(i)) && at_boundary[i]) begin
                  load[i] = 1'b1;
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge Master_Clock_In or negedge Reset_N) begin
      if (!Reset_N) begin
         state_q    <= StIdle;
         pend_ch_q  <= '0;
         pend_div_q <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         pend_ch_q  <= pend_ch_d;
         pend_div_q <= pend_div_d;
         err_q      <= err_d;
      end
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : gen_ch
      clock_enable_channel #(
         .DIV_W       (DIV_W),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
         .clk_i         (Master_Clock_In),
         .rst_ni        (Reset_N),
         .en_i          (Channel_Enable[g]),
         .load_i        (load[g]),
         .load_div_i    (pend_div_q),
         .tick_o        (Tick_Out[g]),
         .at_boundary_o (at_boundary[g])
      );
   end

endmodule

// File: tb/tb_clock_enable_scheduler.sv
// Directed bench for clock_enable_scheduler: reset ticks, boundary-aligned reconfiguration,
// park/every-cycle divisors, bad channel index, disable while pending and mid-run reset.
module tb_clock_enable_scheduler;

   logic       clk;
   logic       rst_n;
   logic [2:0] en;
   logic [2:0] tick;
   int         checks;
   int         errors;
   int         cyc;

   clock_enable_scheduler_if #(.NUM_CH(3), .DIV_W(8)) cfg_if ();

   clock_enable_scheduler #(
      .NUM_CH      (3),
      .DIV_W       (8),
      .DEFAULT_DIV (4)
   ) dut (
      .Master_Clock_In (clk),
      .Reset_N         (rst_n),
      .Channel_Enable  (en),
      .cfg             (cfg_if),
      .Tick_Out        (tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One rising edge, then settle on the falling edge where outputs are sampled
   task automatic step();
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic drive_cfg(input logic v, input logic [1:0] ch, input logic [7:0] dv);
      cfg_if.Cfg_Valid   = v;
      cfg_if.Cfg_Channel = ch;
      cfg_if.Cfg_Divisor = dv;
   endtask

   task automatic test_reset();
      logic [2:0] exp;
      rst_n = 1'b0;
      en    = 3'b111;
      drive_cfg(1'b0, 2'd0, 8'd0);
      repeat (2) @(negedge clk);
      checks++;
      if (tick !== 3'b000) begin
         errors++;
         $display("FAIL reset_tick got=%b exp=000", tick);
      end
      checks++;
      if (cfg_if.Cfg_Ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready got=%b exp=1", cfg_if.Cfg_Ready);
      end
      checks++;
      if (cfg_if.Cfg_Error !== 1'b0) begin
         errors++;
         $display("FAIL reset_error got=%b exp=0", cfg_if.Cfg_Error);
      end
      rst_n = 1'b1;
      cyc   = 0;
      for (int e = 1; e <= 12; e++) begin
         step();
         exp = (cyc % 4 == 0) ? 3'b111 : 3'b000;
         checks++;
         if (tick !== exp) begin
            errors++;
            $display("FAIL reset_ticks edge=%0d got=%b exp=%b", cyc, tick, exp);
         end
      end
   endtask

   task automatic test_reconfig();
      logic [2:0] exp;
      step();  // edge 13: channel 0 count is 1
      drive_cfg(1'b1, 2'd0, 8'd6);
      step();  // edge 14: accepted
      drive_cfg(1'b0, 2'd0, 8'd0);
      checks++;
      if (cfg_if.Cfg_Ready !== 1'b0) begin
         errors++;
         $display("FAIL reconfig_ready_low edge=%0d got=%b exp=0", cyc, cfg_if.Cfg_Ready);
      end
      step();  // edge 15
      checks++;
      if (cfg_if.Cfg_Ready !== 1'b0 || tick !== 3'b000) begin
         errors++;
         $display("FAIL reconfig_wait edge=%0d ready=%b tick=%b exp ready=0 tick=000",
                  cyc, cfg_if.Cfg_Ready, tick);
      end
      step();  // edge 16: old-period tick plus apply
      checks++;
      if (cfg_if.Cfg_Ready !== 1'b1 || tick !== 3'b111) begin
         errors++;
         $display("FAIL reconfig_apply edge=%0d ready=%b tick=%b exp ready=1 tick=111",
                  cyc, cfg_if.Cfg_Ready, tick);
      end
      for (int e = 17; e <= 28; e++) begin
         step();
         exp[0] = (cyc == 22) || (cyc == 28);
         exp[1] = (cyc % 4 == 0);
         exp[2] = (cyc % 4 == 0);
         checks++;
         if (tick !== exp) begin
            errors++;
            $display("FAIL reconfig_spacing edge=%0d got=%b exp=%b", cyc, tick, exp);
         end
      end
   endtask

   task automatic test_div_edges();
      logic exp1;
      drive_cfg(1'b1, 2'd1, 8'd0);
      step();  // edge 29: park request accepted
      drive_cfg(1'b1, 2'd1, 8'd1);
      checks++;
      if (cfg_if.Cfg_Ready !== 1'b0) begin
         errors++;
         $display("FAIL div_stall edge=%0d got=%b exp=0", cyc, cfg_if.Cfg_Ready);
      end
      for (int e = 30; e <= 31; e++) begin
         step();
         checks++;
         if (cfg_if.Cfg_Ready !== 1'b0 || tick[1] !== 1'b0) begin
            errors++;
            $display("FAIL div_stall_hold edge=%0d ready=%b tick1=%b exp ready=0 tick1=0",
                     cyc, cfg_if.Cfg_Ready, tick[1]);
         end
      end
      step();  // edge 32: last tick of old period, park applied
      checks++;
      if (cfg_if.Cfg_Ready !== 1'b1 || tick[1] !== 1'b1) begin
         errors++;
         $display("FAIL div_park_apply edge=%0d ready=%b tick1=%b exp ready=1 tick1=1",
                  cyc, cfg_if.Cfg_Ready, tick[1]);
      end
      step();  // edge 33: second request accepted
      drive_cfg(1'b0, 2'd0, 8'd0);
      checks++;
      if (cfg_if.Cfg_Ready !== 1'b0 || tick[1] !== 1'b0) begin
         errors++;
         $display("FAIL div_second_accept edge=%0d ready=%b tick1=%b exp ready=0 tick1=0",
                  cyc, cfg_if.Cfg_Ready, tick[1]);
      end
      step();  // edge 34: parked channel loads immediately
      checks++;
      if (cfg_if.Cfg_Ready !== 1'b1 || tick[1] !== 1'b0) begin
         errors++;
         $display("FAIL div_parked_apply edge=%0d ready=%b tick1=%b exp ready=1 tick1=0",
                  cyc, cfg_if.Cfg_Ready, tick[1]);
      end
      for (int e = 35; e <= 40; e++) begin
         step();
         exp1 = 1'b1;
         checks++;
         if (tick[1] !== exp1) begin
            errors++;
            $display("FAIL div_every edge=%0d got=%b exp=%b", cyc, tick[1], exp1);
         end
      end
   endtask

   task automatic test_bad_channel();
      logic [2:0] exp;
      drive_cfg(1'b1, 2'd3, 8'd9);
      #1;
      checks++;
      if (cfg_if.Cfg_Ready !== 1'b1) begin
         errors++;
         $display("FAIL bad_ready_pre got=%b exp=1", cfg_if.Cfg_Ready);
      end
      step();  // edge 41
      drive_cfg(1'b0, 2'd0, 8'd0);
      checks++;
      if (cfg_if.Cfg_Error !== 1'b1 || cfg_if.Cfg_Ready !== 1'b1) begin
         errors++;
         $display("FAIL bad_error_pulse edge=%0d err=%b ready=%b exp err=1 ready=1",
                  cyc, cfg_if.Cfg_Error, cfg_if.Cfg_Ready);
      end
      for (int e = 42; e <= 48; e++) begin
         step();
         exp[0] = (cyc == 46);
         exp[1] = 1'b1;
         exp[2] = (cyc % 4 == 0);
         checks++;
         if (cfg_if.Cfg_Error !== 1'b0 || tick !== exp) begin
            errors++;
            $display("FAIL bad_no_change edge=%0d err=%b tick=%b exp err=0 tick=%b",
                     cyc, cfg_if.Cfg_Error, tick, exp);
         end
      end
   endtask

   task automatic test_disable_pending();
      logic exp2;
      drive_cfg(1'b1, 2'd2, 8'd5);
      step();  // edge 49: accepted mid-period
      drive_cfg(1'b0, 2'd0, 8'd0);
      checks++;
      if (cfg_if.Cfg_Ready !== 1'b0) begin
         errors++;
         $display("FAIL dis_pending edge=%0d got=%b exp=0", cyc, cfg_if.Cfg_Ready);
      end
      en = 3'b011;
      step();  // edge 50: disable applies at once
      checks++;
      if (cfg_if.Cfg_Ready !== 1'b1 || tick[2] !== 1'b0) begin
         errors++;
         $display("FAIL dis_apply edge=%0d ready=%b tick2=%b exp ready=1 tick2=0",
                  cyc, cfg_if.Cfg_Ready, tick[2]);
      end
      step();  // edge 51
      checks++;
      if (tick[2] !== 1'b0) begin
         errors++;
         $display("FAIL dis_quiet edge=%0d got=%b exp=0", cyc, tick[2]);
      end
      en = 3'b111;
      for (int e = 52; e <= 61; e++) begin
         step();
         exp2 = (cyc == 56) || (cyc == 61);
         checks++;
         if (tick[2] !== exp2) begin
            errors++;
            $display("FAIL dis_reenable edge=%0d got=%b exp=%b", cyc, tick[2], exp2);
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [2:0] exp;
      drive_cfg(1'b1, 2'd0, 8'd10);
      step();  // edge 62: pending on channel 0
      drive_cfg(1'b0, 2'd0, 8'd0);
      checks++;
      if (cfg_if.Cfg_Ready !== 1'b0 || tick[1] !== 1'b1) begin
         errors++;
         $display("FAIL rmid_pre edge=%0d ready=%b tick1=%b exp ready=0 tick1=1",
                  cyc, cfg_if.Cfg_Ready, tick[1]);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (tick !== 3'b000 || cfg_if.Cfg_Ready !== 1'b1 || cfg_if.Cfg_Error !== 1'b0) begin
         errors++;
         $display("FAIL rmid_async tick=%b ready=%b err=%b exp tick=000 ready=1 err=0",
                  tick, cfg_if.Cfg_Ready, cfg_if.Cfg_Error);
      end
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      cyc   = 0;
      for (int e = 1; e <= 8; e++) begin
         step();
         exp = (cyc % 4 == 0) ? 3'b111 : 3'b000;
         checks++;
         if (tick !== exp || cfg_if.Cfg_Ready !== 1'b1) begin
            errors++;
            $display("FAIL rmid_defaults edge=%0d tick=%b ready=%b exp tick=%b ready=1",
                     cyc, tick, cfg_if.Cfg_Ready, exp);
         end
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      cyc    = 0;
      test_reset();
      test_reconfig();
      test_div_edges();
      test_bad_channel();
      test_disable_pending();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
